// File: rtl/cymometer_core.sv
// Equal-precision frequency meter.
// Samples clk_fx in the sys_clk domain, counts whole clk_fx periods (fx_cnt) and
// sys_clk cycles (fs_cnt) over a gate whose both ends sit on clk_fx rising edges,
// then computes f = fx_cnt * CLK_FS / fs_cnt (rounded) with a restoring divider.
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   clk_fx      in   signal under test, asynchronous to sys_clk
//   data        out  last measured frequency in Hz, held until the next result
//   data_valid  out  one-cycle pulse when data updates
//   fx_absent   out  1 = last measurement timed out (data forced to 0)
module cymometer_core #(
    parameter int unsigned CLK_FS         = 50_000_000,
    parameter int unsigned GATE_CYCLES    = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned IDLE_CYCLES    = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clk_fx,
    output logic [29:0] data,
    output logic        data_valid,
    output logic        fx_absent
);

    localparam int unsigned CW   = 32;  // idle / gate / timeout counters
    localparam int unsigned FXW  = 30;
    localparam int unsigned FSW  = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned STW  = 7;
    localparam int unsigned DIV_STEPS = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_DIV,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       fx_sync_q;
    logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             soft_done_q, soft_done_d;
    logic [FXW-1:0]   fx_cnt_q, fx_cnt_d;
    logic [FSW-1:0]   fs_cnt_q, fs_cnt_d;
    logic [DW-1:0]    dvd_q, dvd_d;      // dividend shifts out MSB-first, quotient shifts in
    logic [FSW-1:0]   rem_q, rem_d;
    logic [STW-1:0]   step_q, step_d;
    logic [29:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             absent_q, absent_d;

    logic             fx_rise_c;
    logic             timeout_c;
    logic [FSW:0]     rem_shift_c;
    logic [FSW:0]     rem_diff_c;
    logic             rem_ge_c;
    logic [DW-1:0]    quo_next_c;
    logic [29:0]      quo_sat_c;

    // fx_sync_q[0]/[1] are the synchroniser, [2] is the edge-detect delay
    assign fx_rise_c = fx_sync_q[1] & ~fx_sync_q[2];
    assign timeout_c = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // One restoring-division step; divisor fs_cnt_q is frozen while dividing
    assign rem_shift_c = {rem_q, dvd_q[DW-1]};
    assign rem_ge_c    = (rem_shift_c >= {1'b0, fs_cnt_q});
    assign rem_diff_c  = rem_shift_c - {1'b0, fs_cnt_q};
    assign quo_next_c  = {dvd_q[DW-2:0], rem_ge_c};
    assign quo_sat_c   = (|quo_next_c[DW-1:30]) ? 30'h3FFF_FFFF : quo_next_c[29:0];

    assign data       = data_q;
    assign data_valid = valid_q;
    assign fx_absent  = absent_q;

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            fx_sync_q   <= '0;
            idle_cnt_q  <= '0;
            gate_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            soft_done_q <= 1'b0;
            fx_cnt_q    <= '0;
            fs_cnt_q    <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            step_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            absent_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fx_sync_q   <= {fx_sync_q[1:0], clk_fx};
            idle_cnt_q  <= idle_cnt_d;
            gate_cnt_q  <= gate_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            soft_done_q <= soft_done_d;
            fx_cnt_q    <= fx_cnt_d;
            fs_cnt_q    <= fs_cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            step_q      <= step_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            absent_q    <= absent_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        gate_cnt_d  = gate_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        soft_done_d = soft_done_q;
        fx_cnt_d    = fx_cnt_q;
        fs_cnt_d    = fs_cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        step_d      = step_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        absent_d    = absent_q;

        case (state_q)
            S_IDLE: begin
                gate_cnt_d  = '0;
                tmo_cnt_d   = '0;
                soft_done_d = 1'b0;
                if (idle_cnt_q == CW'(IDLE_CYCLES - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = S_ARM;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end

            S_ARM, S_GATE: begin
                gate_cnt_d = gate_cnt_q + CW'(1);
                tmo_cnt_d  = tmo_cnt_q + CW'(1);
                if (gate_cnt_q == CW'(GATE_CYCLES - 1)) begin
                    soft_done_d = 1'b1;
                end
                if (state_q == S_GATE) begin
                    fs_cnt_d = (&fs_cnt_q) ? fs_cnt_q : fs_cnt_q + FSW'(1);
                    if (fx_rise_c) begin
                        fx_cnt_d = (&fx_cnt_q) ? fx_cnt_q : fx_cnt_q + FXW'(1);
                    end
                end
                if (timeout_c) begin
                    // Timeout beats a coincident closing edge
                    data_d     = '0;
                    absent_d   = 1'b1;
                    valid_d    = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (state_q == S_ARM && fx_rise_c) begin
                    fx_cnt_d = '0;
                    fs_cnt_d = '0;
                    state_d  = S_GATE;
                end else if (state_q == S_GATE && fx_rise_c && soft_done_q) begin
                    step_d  = '0;
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                if (step_q == '0) begin
                    // Adding fs_cnt/2 turns the truncating divide into round-to-nearest
                    dvd_d  = DW'(fx_cnt_q) * DW'(CLK_FS) + DW'(fs_cnt_q >> 1);
                    rem_d  = '0;
                    step_d = STW'(1);
                end else begin
                    dvd_d  = quo_next_c;
                    rem_d  = rem_ge_c ? rem_diff_c[FSW-1:0] : rem_shift_c[FSW-1:0];
                    step_d = step_q + STW'(1);
                    if (step_q == STW'(DIV_STEPS)) begin
                        data_d   = quo_sat_c;
                        absent_d = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                idle_cnt_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cymometer_core.sv
// Self-checking bench for cymometer_core. clk_fx is generated on sys_clk falling
// edges with an integer period P, so the ideal reading is round(CLK_FS / P).
module tb_cymometer_core;

    localparam int unsigned CLK_FS  = 50_000_000;
    localparam int unsigned GATE    = 1000;
    localparam int unsigned TMO     = 4000;
    localparam int unsigned IDLE    = 10;
    localparam int unsigned BUDGET  = 12000;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        clk_fx    = 1'b0;
    logic [29:0] data;
    logic        data_valid;
    logic        fx_absent;

    int n_vec = 0;
    int n_err = 0;

    int unsigned fx_period = 0;  // 0 = clk_fx held low
    int unsigned fx_high   = 0;
    int unsigned fx_ph     = 0;
    int unsigned fx_last_p = 0;

    cymometer_core #(
        .CLK_FS         (CLK_FS),
        .GATE_CYCLES    (GATE),
        .TIMEOUT_CYCLES (TMO),
        .IDLE_CYCLES    (IDLE)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clk_fx     (clk_fx),
        .data       (data),
        .data_valid (data_valid),
        .fx_absent  (fx_absent)
    );

    always #10 sys_clk = ~sys_clk;

    // Signal-under-test generator; a period change restarts the waveform at once
    always @(negedge sys_clk) begin
        if (fx_period != fx_last_p) begin
            fx_last_p = fx_period;
            fx_ph     = 0;
        end else if (fx_period != 0) begin
            fx_ph = (fx_ph + 1 >= fx_period) ? 0 : fx_ph + 1;
        end
        clk_fx = (fx_period != 0) && (fx_ph < fx_high);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: ideal frequency of a P-cycle signal, rounded half up
    function automatic logic [31:0] ref_freq(input int unsigned p);
        longint unsigned f;
        f = (longint'(CLK_FS) + longint'(p / 2)) / longint'(p);
        return 32'(f);
    endfunction

    // data may only move on a data_valid cycle, and data_valid is a single-cycle pulse
    logic [29:0] prev_data  = '0;
    logic        prev_valid = 1'b0;
    logic        prev_rst   = 1'b0;
    always @(negedge sys_clk) begin
        if (sys_rst_n && prev_rst && !data_valid)
            check_eq("data_hold", 32'(data), 32'(prev_data));
        if (data_valid)
            check_eq("valid_width", 32'(prev_valid), 32'd0);
        prev_data  = data;
        prev_valid = data_valid;
        prev_rst   = sys_rst_n;
    end

    task automatic set_fx(input int unsigned p, input int unsigned h);
        fx_period = p;
        fx_high   = h;
    endtask

    task automatic wait_valid(input string tag, output logic [29:0] d, output logic a,
                              output int unsigned cyc);
        bit seen = 1'b0;
        cyc = 0;
        d   = '0;
        a   = 1'b0;
        while (!seen && cyc < BUDGET) begin
            @(negedge sys_clk);
            cyc++;
            if (data_valid) begin
                seen = 1'b1;
                d    = data;
                a    = fx_absent;
            end
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic expect_freq(input string tag, input int unsigned p);
        logic [29:0] d;
        logic        a;
        int unsigned c;
        wait_valid(tag, d, a, c);
        check_eq(tag, 32'(d), ref_freq(p));
        check_eq({tag, "_absent"}, 32'(a), 32'd0);
    endtask

    task automatic discard(input string tag);
        logic [29:0] d;
        logic        a;
        int unsigned c;
        wait_valid(tag, d, a, c);
    endtask

    task automatic expect_timeout(input string tag, input bit chk_spacing);
        logic [29:0] d;
        logic        a;
        int unsigned c;
        wait_valid(tag, d, a, c);
        check_eq(tag, 32'(d), 32'd0);
        check_eq({tag, "_absent"}, 32'(a), 32'd1);
        // previous pulse -> IDLE_CYCLES of idle -> TIMEOUT_CYCLES in ARM -> pulse
        if (chk_spacing)
            check_eq({tag, "_spacing"}, c, IDLE + TMO);
    endtask

    initial begin
        int unsigned p;
        int unsigned h;

        // Reset state
        #1 sys_rst_n = 1'b0;
        #1;
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_absent", 32'(fx_absent), 32'd0);
        set_fx(50, 25);
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 1 MHz
        expect_freq("f1m_a", 50);
        expect_freq("f1m_b", 50);

        // Period 3: rounding, repeated results
        set_fx(3, 1);
        discard("p3_skip");
        expect_freq("p3_a", 3);
        expect_freq("p3_b", 3);
        expect_freq("p3_c", 3);

        // Stuck low: timeouts spaced by idle + timeout
        set_fx(0, 0);
        discard("stuck_skip");
        expect_timeout("tmo_a", 1'b1);
        expect_timeout("tmo_b", 1'b1);

        // A real signal clears fx_absent
        set_fx(50, 20);
        discard("recover_skip");
        expect_freq("recover", 50);

        // Slower than the gate: closes on the second edge
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        set_fx(0, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (15) @(negedge sys_clk);
        set_fx(3000, 1500);
        expect_freq("p3000", 3000);

        // Reset in the middle of a gate
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        set_fx(50, 25);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        expect_freq("pre_rst", 50);
        repeat (600) @(negedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1;
        check_eq("midgate_data", 32'(data), 32'd0);
        check_eq("midgate_valid", 32'(data_valid), 32'd0);
        check_eq("midgate_absent", 32'(fx_absent), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        expect_freq("post_rst", 50);

        // Frequency change while the divider runs (close lands 1011..1060 cycles after the pulse)
        repeat (1070) @(negedge sys_clk);
        set_fx(20, 10);
        expect_freq("sw_old", 50);
        expect_freq("sw_new", 20);

        // Random periods and duty cycles
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(1000, 4);
            h = $urandom_range(p - 1, 1);
            set_fx(p, h);
            discard("rand_skip");
            expect_freq($sformatf("rand_p%0d", p), p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
